// File: rtl/a_rom_reader.sv
// a_rom_reader: streams the packed A-matrix ROM as 7-bit entries on a
// valid/ready interface, high half of each 14-bit word first.
// Optional build macro: A_RD_PREFETCH_EN fetches word a+1 while word a is
// being emitted, giving one entry per cycle when the consumer keeps up.
module a_rom_reader #(
  parameter int NUM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  rom_addr,
  input  logic [13:0] A_input,
  output logic [6:0]  elem_data,
  output logic [4:0]  elem_idx,
  output logic        elem_valid,
  input  logic        elem_ready,
  output logic        elem_last,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_F1, S_F2, S_HI, S_LO} state_t;

  state_t      state_q, state_d;
  logic [3:0]  rom_addr_q, rom_addr_d;
  logic [3:0]  word_q, word_d;
  logic [13:0] word_buf_q, word_buf_d;
  logic [6:0]  elem_data_q, elem_data_d;
  logic [4:0]  elem_idx_q, elem_idx_d;
  logic        elem_valid_q, elem_valid_d;
  logic        elem_last_q, elem_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        handshake;
  logic        load_hi;
  logic [3:0]  load_word;
  logic [13:0] load_data;

`ifdef A_RD_PREFETCH_EN
  logic [13:0] pf_buf_q, pf_buf_d;
  logic        pf_valid_q, pf_valid_d;
  logic [1:0]  pf_cnt_q, pf_cnt_d;
  logic        pf_arrive;
`endif

  assign handshake = elem_valid_q & elem_ready;

  // Next-state and output computation; load_hi funnels every entry into HI.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    word_d       = word_q;
    word_buf_d   = word_buf_q;
    elem_data_d  = elem_data_q;
    elem_idx_d   = elem_idx_q;
    elem_valid_d = elem_valid_q;
    elem_last_d  = elem_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load_hi      = 1'b0;
    load_word    = word_q;
    load_data    = A_input;
`ifdef A_RD_PREFETCH_EN
    pf_buf_d   = pf_buf_q;
    pf_valid_d = pf_valid_q;
    // Counter value 1 marks the edge at which the prefetched word is on A_input.
    pf_arrive  = (pf_cnt_q == 2'd1);
    pf_cnt_d   = (pf_cnt_q != 2'd0) ? pf_cnt_q - 2'd1 : 2'd0;
    if (pf_arrive) begin
      pf_buf_d   = A_input;
      pf_valid_d = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rom_addr_d = 4'd0;
          word_d     = 4'd0;
          busy_d     = 1'b1;
          state_d    = S_F1;
`ifdef A_RD_PREFETCH_EN
          pf_valid_d = 1'b0;
          pf_cnt_d   = 2'd0;
`endif
        end
      end
      S_F1: state_d = S_F2;
      S_F2: begin
`ifdef A_RD_PREFETCH_EN
        if (pf_valid_q) begin
          load_hi    = 1'b1;
          load_data  = pf_buf_q;
          pf_valid_d = 1'b0;
        end else if (pf_cnt_q != 2'd2) begin
          load_hi    = 1'b1;
          pf_valid_d = 1'b0;
        end
`else
        load_hi = 1'b1;
`endif
      end
      S_HI: begin
        if (handshake) begin
          state_d     = S_LO;
          elem_data_d = word_buf_q[6:0];
          elem_idx_d  = {word_q, 1'b1};
          elem_last_d = (word_q == LAST_WORD);
        end
      end
      S_LO: begin
        if (handshake) begin
          elem_valid_d = 1'b0;
          elem_last_d  = 1'b0;
          if (word_q == LAST_WORD) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            word_d = word_q + 4'd1;
`ifdef A_RD_PREFETCH_EN
            load_word = word_q + 4'd1;
            if (pf_valid_q) begin
              load_hi    = 1'b1;
              load_data  = pf_buf_q;
              pf_valid_d = 1'b0;
            end else if (pf_arrive) begin
              load_hi    = 1'b1;
              pf_valid_d = 1'b0;
            end else begin
              state_d = S_F2;
            end
`else
            rom_addr_d = word_q + 4'd1;
            state_d    = S_F1;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_hi) begin
      state_d      = S_HI;
      word_buf_d   = load_data;
      elem_valid_d = 1'b1;
      elem_data_d  = load_data[13:7];
      elem_idx_d   = {load_word, 1'b0};
      elem_last_d  = 1'b0;
`ifdef A_RD_PREFETCH_EN
      // Launch the next word's fetch as soon as the current word is in hand.
      if (load_word != LAST_WORD) begin
        rom_addr_d = load_word + 4'd1;
        pf_cnt_d   = 2'd2;
      end
`endif
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= 4'd0;
      word_q       <= 4'd0;
      word_buf_q   <= 14'd0;
      elem_data_q  <= 7'd0;
      elem_idx_q   <= 5'd0;
      elem_valid_q <= 1'b0;
      elem_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef A_RD_PREFETCH_EN
      pf_buf_q     <= 14'd0;
      pf_valid_q   <= 1'b0;
      pf_cnt_q     <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      word_q       <= word_d;
      word_buf_q   <= word_buf_d;
      elem_data_q  <= elem_data_d;
      elem_idx_q   <= elem_idx_d;
      elem_valid_q <= elem_valid_d;
      elem_last_q  <= elem_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef A_RD_PREFETCH_EN
      pf_buf_q     <= pf_buf_d;
      pf_valid_q   <= pf_valid_d;
      pf_cnt_q     <= pf_cnt_d;
`endif
    end
  end

  assign rom_addr   = rom_addr_q;
  assign elem_data  = elem_data_q;
  assign elem_idx   = elem_idx_q;
  assign elem_valid = elem_valid_q;
  assign elem_last  = elem_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_a_rom_reader.sv
// Testbench for a_rom_reader: a stream-level model predicts the entry
// sequence, busy/done and pass length; a second instance covers NUM_WORDS=1.
module tb_a_rom_reader;
  localparam int NW = 16;
  localparam int NE = 2 * NW;
`ifdef A_RD_PREFETCH_EN
  localparam int EXP_LEN = 2 * NW + 2;
`else
  localparam int EXP_LEN = 4 * NW;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, elem_ready;
  logic [3:0]  rom_addr;
  logic [13:0] A_input;
  logic [6:0]  elem_data;
  logic [4:0]  elem_idx;
  logic        elem_valid, elem_last, busy, done;
  logic [13:0] rom [16];

  logic        start1, ready1;
  logic [3:0]  rom_addr1;
  logic [13:0] A_input1;
  logic [6:0]  data1;
  logic [4:0]  idx1;
  logic        valid1, last1, busy1, done1;

  // ROMs with one-cycle registered read
  always @(posedge clk) A_input <= rom[rom_addr];
  always @(posedge clk) A_input1 <= (rom_addr1 == 4'd0) ? {7'd1, 7'd2} : 14'h3fff;

  a_rom_reader #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .A_input(A_input),
    .elem_data(elem_data), .elem_idx(elem_idx), .elem_valid(elem_valid),
    .elem_ready(elem_ready), .elem_last(elem_last), .busy(busy), .done(done));

  a_rom_reader #(.NUM_WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rom_addr(rom_addr1), .A_input(A_input1),
    .elem_data(data1), .elem_idx(idx1), .elem_valid(valid1),
    .elem_ready(ready1), .elem_last(last1), .busy(busy1), .done(done1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_entry(input int i);
    logic [13:0] w;
    w = rom[i / 2];
    if (i % 2 == 0) return w[13:7];
    return w[6:0];
  endfunction

  // Stream model state
  bit         m_busy = 0, m_done = 0, m_ready_ok = 0, prev_stall = 0, m_accept = 0;
  int         m_ptr = 0, m_since = 0, edge_n = 0, m_start_edge = 0, last_len = 0;
  logic [6:0] prev_data = 7'd0;
  logic [6:0] got_q [$];

  // Compare outputs every cycle, then predict the effect of the next rising edge.
  always @(negedge clk) begin
    edge_n++;
    if (!rst) begin
      chk("rst_outs", int'({rom_addr, elem_data, elem_idx, elem_valid, elem_last, busy, done}), 0);
      m_busy = 0; m_done = 0; m_ptr = 0; prev_stall = 0; m_since = 0;
    end else begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      if (!m_busy) chk("valid_idle", int'(elem_valid), 0);
      else if (m_since < 2) chk("valid_fetch", int'(elem_valid), 0);
      else if (m_since == 2) chk("first_latency", int'(elem_valid), 1);
      if (prev_stall) begin
        chk("stall_valid", int'(elem_valid), 1);
        chk("stall_data", int'(elem_data), int'(prev_data));
      end
      if (elem_valid) begin
        chk("data", int'(elem_data), int'(exp_entry(m_ptr)));
        chk("idx", int'(elem_idx), m_ptr);
        chk("last", int'(elem_last), int'(m_ptr == NE - 1));
      end
      prev_stall = elem_valid && !elem_ready;
      prev_data  = elem_data;
      m_done     = 0;
      m_accept   = start && !m_busy;
      if (m_busy && !elem_ready) m_ready_ok = 0;
      if (elem_valid && elem_ready) begin
        got_q.push_back(elem_data);
        if (m_ptr == NE - 1) begin
          m_done   = 1;
          m_busy   = 0;
          last_len = edge_n - m_start_edge;
          if (m_ready_ok) chk("pass_len", last_len, EXP_LEN);
          m_ptr = 0;
        end else begin
          m_ptr++;
        end
      end
      if (m_busy && m_since < 100) m_since++;
      if (m_accept) begin
        m_busy = 1; m_ptr = 0; m_since = 0; m_start_edge = edge_n; m_ready_ok = 1;
        got_q.delete();
      end
    end
  end

  // Stimulus controls
  int ready_mode = 0;   // 0 high, 1 pattern 1,0,0,1, 2 random, 3 hold
  bit spam = 0;
  int pc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    case (ready_mode)
      0: elem_ready = 1'b1;
      1: begin elem_ready = (pc % 4 == 0) || (pc % 4 == 3); pc++; end
      2: elem_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
    if (spam && busy && $urandom_range(0, 5) == 0) start = 1'b1;
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin tick(); n++; end
    chk("done_seen", int'(done === 1'b1), 1);
  endtask

  task automatic set_rom_inc();
    for (int a = 0; a < 16; a++) rom[a] = {7'(2 * a + 1), 7'(2 * a + 2)};
  endtask

  task automatic set_rom_rand();
    for (int a = 0; a < 16; a++) rom[a] = 14'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dn;
    logic [6:0] g1 [$];
    rst = 1'b0; start = 1'b0; elem_ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
    set_rom_inc();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'({rom_addr, elem_data, elem_idx, elem_valid, elem_last, busy, done}), 0);
    rst = 1'b1;
    tick(); tick();

    // Pass 1: ready high, incrementing ROM
    start_pass();
    wait_done(400);
    tick();
    chk("p1_count", got_q.size(), NE);
    if (got_q.size() == NE) begin
      chk("p1_first", int'(got_q[0]), 1);
      chk("p1_final", int'(got_q[NE - 1]), 32);
    end
    chk("p1_len", last_len, EXP_LEN);
    chk("p1_busy_after", int'(busy), 0);

    // Pass 2: ready 1,0,0,1 with start spam during the pass
    ready_mode = 1; pc = 0; spam = 1;
    start_pass();
    wait_done(800);
    chk("p2_count", got_q.size(), NE);

    // Pass 3 and 4: restart in the done cycle
    ready_mode = 0; spam = 0;
    start_pass();
    wait_done(400);
    start = 1'b1;
    tick();
    chk("restart_addr", int'(rom_addr), 0);
    chk("restart_busy", int'(busy), 1);
    wait_done(400);
    chk("p4_count", got_q.size(), NE);
    if (got_q.size() > 0) chk("p4_first", int'(got_q[0]), 1);
    chk("p4_len", last_len, EXP_LEN);

    // Random ROM contents, random ready, start spam
    ready_mode = 2; spam = 1;
    repeat (4) begin
      set_rom_rand();
      tick();
      start_pass();
      wait_done(1500);
      chk("rand_count", got_q.size(), NE);
      tick();
    end

    // Reset in the middle of a pass at idx 9
    set_rom_inc(); spam = 0;
    start_pass();
    n = 0;
    while (!(elem_valid && elem_idx == 5'd9) && n < 500) begin tick(); n++; end
    chk("reach_idx9", int'(elem_idx), 9);
    rst = 1'b0;
    #1;
    chk("rst_midpass", int'({rom_addr, elem_data, elem_idx, elem_valid, elem_last, busy, done}), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    ready_mode = 0;
    start_pass();
    wait_done(400);
    chk("post_rst_count", got_q.size(), NE);
    if (got_q.size() > 0) chk("post_rst_first", int'(got_q[0]), 1);
    tick();

`ifdef A_RD_PREFETCH_EN
    // Long stall on idx 1 must leave word 1 waiting in the prefetch buffer
    ready_mode = 3; elem_ready = 1'b1;
    start_pass();
    n = 0;
    while (!(elem_valid && elem_idx == 5'd1) && n < 50) begin tick(); n++; end
    chk("pf_reach_idx1", int'(elem_idx), 1);
    elem_ready = 1'b0;
    repeat (10) tick();
    elem_ready = 1'b1;
    tick();
    chk("pf_valid", int'(elem_valid), 1);
    chk("pf_idx", int'(elem_idx), 2);
    chk("pf_data", int'(elem_data), 3);
    ready_mode = 0;
    wait_done(400);
    tick();
`endif

    // NUM_WORDS=1 instance
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      chk("nw1_addr", int'(rom_addr1), 0);
      if (valid1 && ready1) begin
        g1.push_back(data1);
        chk("nw1_last", int'(last1), int'(g1.size() == 2));
      end
      if (done1) dn++;
      tick();
    end
    chk("nw1_count", g1.size(), 2);
    if (g1.size() == 2) begin
      chk("nw1_v0", int'(g1[0]), 1);
      chk("nw1_v1", int'(g1[1]), 2);
    end
    chk("nw1_done_count", dn, 1);
    chk("nw1_busy_after", int'(busy1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
